// File: rtl/puf_key_gen.sv
// puf_key_gen: sequences settle/excite/sample cycles on an external arbiter-PUF
// array and majority-votes NUM_EVALS responses per bit into a key plus a mask
// of bits whose responses were not unanimous.
module puf_key_gen #(
    parameter int NUM_PUF       = 8,
    parameter int CHAL_W        = 64,
    parameter int SETTLE_CYCLES = 100,
    parameter int RESP_DELAY    = 2,
    parameter int NUM_EVALS     = 7,
    localparam int EV_W         = $clog2(NUM_EVALS + 1)
) (
    input  logic                Clk,
    input  logic                Rst_n,
    input  logic                start,
    input  logic [CHAL_W-1:0]   challenge,
    input  logic [NUM_PUF-1:0]  puf_resp,
    output logic [CHAL_W-1:0]   chal_out,
    output logic                excite_l,
    output logic                excite_r,
    output logic                busy,
    output logic                key_valid,
    output logic [NUM_PUF-1:0]  key,
    output logic [NUM_PUF-1:0]  unstable,
    output logic [EV_W-1:0]     eval_idx
);

    // One down-counter serves both the settle and the response-delay phases.
    localparam int MAXD  = (SETTLE_CYCLES > RESP_DELAY) ? SETTLE_CYCLES : RESP_DELAY;
    localparam int CNT_W = $clog2(MAXD + 1);

    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAIT_LD   = CNT_W'(RESP_DELAY - 1);
    localparam logic [EV_W-1:0]  LAST_EVAL = EV_W'(NUM_EVALS - 1);
    localparam logic [EV_W-1:0]  HALF      = EV_W'(NUM_EVALS / 2);
    localparam logic [EV_W-1:0]  FULL      = EV_W'(NUM_EVALS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_EXCITE,
        S_WAIT,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              excite_q;
    logic [EV_W-1:0]   ones_cnt [NUM_PUF];

    // NUM_EVALS is odd, so 2*c > NUM_EVALS is the same as c > NUM_EVALS/2.
    function automatic logic vote_bit(input logic [EV_W-1:0] c);
        return c > HALF;
    endfunction

    // A bit is unstable unless every evaluation agreed.
    function automatic logic unstable_bit(input logic [EV_W-1:0] c);
        return (c != '0) && (c != FULL);
    endfunction

    // Both excite paths are driven from one register so they can never differ.
    assign excite_l = excite_q;
    assign excite_r = excite_q;

    // Controller FSM with registered outputs and per-bit ones counters.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            chal_out  <= '0;
            excite_q  <= 1'b0;
            busy      <= 1'b0;
            key_valid <= 1'b0;
            key       <= '0;
            unstable  <= '0;
            eval_idx  <= '0;
            for (int i = 0; i < NUM_PUF; i++) ones_cnt[i] <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        chal_out  <= challenge;
                        eval_idx  <= '0;
                        busy      <= 1'b1;
                        key_valid <= 1'b0;
                        cnt       <= SETTLE_LD;
                        state     <= S_SETTLE;
                        for (int i = 0; i < NUM_PUF; i++) ones_cnt[i] <= '0;
                    end
                end
                S_SETTLE: begin
                    if (cnt == '0) begin
                        excite_q <= 1'b1;
                        state    <= S_EXCITE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_EXCITE: begin
                    excite_q <= 1'b0;
                    cnt      <= WAIT_LD;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    // Arbiter outputs are still resolving here; nothing is sampled.
                    if (cnt == '0) state <= S_SAMPLE;
                    else           cnt   <= cnt - CNT_W'(1);
                end
                S_SAMPLE: begin
                    for (int i = 0; i < NUM_PUF; i++)
                        ones_cnt[i] <= ones_cnt[i] + EV_W'(puf_resp[i]);
                    eval_idx <= eval_idx + EV_W'(1);
                    if (eval_idx == LAST_EVAL) begin
                        state <= S_DONE;
                    end else begin
                        cnt   <= SETTLE_LD;
                        state <= S_SETTLE;
                    end
                end
                S_DONE: begin
                    for (int i = 0; i < NUM_PUF; i++) begin
                        key[i]      <= vote_bit(ones_cnt[i]);
                        unstable[i] <= unstable_bit(ones_cnt[i]);
                    end
                    key_valid <= 1'b1;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_puf_key_gen.sv
// tb_puf_key_gen: randomized scoreboard bench for puf_key_gen with a
// second instance configured for a single evaluation per key.
module tb_puf_key_gen;

    localparam int NP  = 8;
    localparam int CW  = 64;
    localparam int S   = 4;
    localparam int R   = 2;
    localparam int N   = 5;
    localparam int EVW = $clog2(N + 1);
    localparam int PER = S + R + 2;

    typedef struct {
        logic [7:0]  key;
        logic [7:0]  unst;
        logic [63:0] chal;
        int          t0;
    } exp_t;

    logic            Clk = 1'b0;
    logic            Rst_n = 1'b0;
    logic            start, start1;
    logic [CW-1:0]   challenge, challenge1;
    logic [NP-1:0]   puf_resp, puf_resp1;
    logic [CW-1:0]   chal_out, chal_out1;
    logic            excite_l, excite_r, excite_l1, excite_r1;
    logic            busy, busy1, key_valid, key_valid1;
    logic [NP-1:0]   key, key1, unstable, unstable1;
    logic [EVW-1:0]  eval_idx;
    logic [0:0]      eval_idx1;

    puf_key_gen #(.NUM_PUF(NP), .CHAL_W(CW), .SETTLE_CYCLES(S), .RESP_DELAY(R), .NUM_EVALS(N)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .start(start), .challenge(challenge), .puf_resp(puf_resp),
        .chal_out(chal_out), .excite_l(excite_l), .excite_r(excite_r), .busy(busy),
        .key_valid(key_valid), .key(key), .unstable(unstable), .eval_idx(eval_idx));

    puf_key_gen #(.NUM_PUF(NP), .CHAL_W(CW), .SETTLE_CYCLES(S), .RESP_DELAY(R), .NUM_EVALS(1)) dut1 (
        .Clk(Clk), .Rst_n(Rst_n), .start(start1), .challenge(challenge1), .puf_resp(puf_resp1),
        .chal_out(chal_out1), .excite_l(excite_l1), .excite_r(excite_r1), .busy(busy1),
        .key_valid(key_valid1), .key(key1), .unstable(unstable1), .eval_idx(eval_idx1));

    always #5 Clk = ~Clk;

    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    int   exc_bad = 0;
    int   exc_cnt = 0;
    int   chal_bad = 0;
    exp_t exp_q[$];
    logic [7:0] rv [N];

    initial forever begin
        @(posedge Clk);
        cyc++;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
    endtask

    // Reference: per-bit count of ones over the evaluations, majority and unanimity.
    task automatic model(output logic [7:0] k, output logic [7:0] u);
        for (int b = 0; b < 8; b++) begin
            int ones = 0;
            for (int e = 0; e < N; e++) ones += int'(rv[e][b]);
            k[b] = (2 * ones > N);
            u[b] = (ones != 0) && (ones != N);
        end
    endtask

    // Monitor: pops an expectation on every rising key_valid.
    initial begin
        logic kv_prev = 1'b0;
        exp_t e;
        forever begin
            @(negedge Clk);
            if (excite_l !== excite_r || excite_l1 !== excite_r1) exc_bad++;
            if (excite_l) exc_cnt++;
            if (key_valid && !kv_prev) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_key_valid", 64'(key_valid), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("key", 64'(key), 64'(e.key));
                    chk("unstable", 64'(unstable), 64'(e.unst));
                    chk("chal_out", chal_out, e.chal);
                    chk("eval_idx_end", 64'(eval_idx), 64'(N));
                    chk("latency", 64'(cyc - e.t0), 64'(N * PER + 2));
                end
            end
            kv_prev = key_valid;
        end
    end

    task automatic reset_check(input string tag);
        Rst_n = 1'b0;
        #1;
        chk({tag, "_chal_out"}, chal_out, 64'(0));
        chk({tag, "_ctrl"}, 64'({busy, key_valid, excite_l, excite_r, eval_idx, key, unstable}), 64'(0));
        @(negedge Clk);
        Rst_n = 1'b1;
    endtask

    // One key-generation run; response for evaluation ev is presented only in its SAMPLE cycle.
    task automatic do_run(input logic [63:0] chal, input bit spam, input int abort_at, input bit hold_end);
        exp_t e;
        logic [7:0] k, u;
        int last, t;
        model(k, u);
        @(negedge Clk);
        challenge = chal;
        start = 1'b1;
        e.key = k; e.unst = u; e.chal = chal; e.t0 = cyc;
        exp_q.push_back(e);
        last = cyc;
        for (int ev = 0; ev < N; ev++) begin
            t = 0;
            do begin
                @(negedge Clk);
                t++;
                start = (spam && ev < N - 1) ? 1'($urandom) : 1'b0;
                if (spam) challenge = {$urandom, $urandom};
                else challenge = 64'(0);
                puf_resp = 8'($urandom);
                if (busy && chal_out !== chal) chal_bad++;
            end while (!excite_l && t < 40);
            chk("excite_seen", 64'(excite_l), 64'(1));
            if (!excite_l) return;
            if (ev == 0) chk("first_excite_delay", 64'(cyc - last), 64'(S + 1));
            else         chk("excite_spacing", 64'(cyc - last), 64'(PER));
            last = cyc;
            if (ev == abort_at) begin
                reset_check("abort");
                void'(exp_q.pop_back());
                start = 1'b0;
                return;
            end
            repeat (R) begin
                @(negedge Clk);
                puf_resp = 8'($urandom);
            end
            @(negedge Clk);
            puf_resp = rv[ev];
        end
        t = 0;
        do begin
            @(negedge Clk);
            t++;
            puf_resp = 8'($urandom);
            if (hold_end) start = 1'b1;
        end while (!key_valid && t < 20);
        chk("key_valid_seen", 64'(key_valid), 64'(1));
        if (hold_end) begin
            chk("busy_at_done", 64'(busy), 64'(0));
            @(negedge Clk);
            chk("restart_clears_kv", 64'(key_valid), 64'(0));
            chk("restart_busy", 64'(busy), 64'(1));
            chk("key_held_on_restart", 64'(key), 64'(k));
            start = 1'b0;
        end
    endtask

    initial begin
        logic [7:0] base;
        logic [22:0] idle_or;
        int t, t0, exc0;
        start = 1'b0; challenge = '0; puf_resp = '0;
        start1 = 1'b0; challenge1 = '0; puf_resp1 = '0;

        repeat (3) @(negedge Clk);
        chk("reset_chal_out", chal_out, 64'(0));
        chk("reset_ctrl", 64'({busy, key_valid, excite_l, eval_idx, key, unstable}), 64'(0));
        Rst_n = 1'b1;

        // Idle without start: nothing moves.
        exc0 = exc_cnt;
        idle_or = '0;
        repeat (20) begin
            @(negedge Clk);
            challenge = {$urandom, $urandom};
            puf_resp = 8'($urandom);
            idle_or |= {busy, key_valid, excite_l, eval_idx, key, unstable, 1'b0, |chal_out};
        end
        chk("idle_outputs", 64'(idle_or), 64'(0));
        chk("idle_no_excite", 64'(exc_cnt - exc0), 64'(0));

        // Constant response.
        for (int e = 0; e < N; e++) rv[e] = 8'hA5;
        do_run(64'h05055F5F55252F2F, 1'b0, -1, 1'b0);

        // Directed vote patterns.
        rv[0] = 8'hFF; rv[1] = 8'h00; rv[2] = 8'hFF; rv[3] = 8'h0F; rv[4] = 8'hF0;
        do_run({$urandom, $urandom}, 1'b0, -1, 1'b0);
        rv[0] = 8'h01; rv[1] = 8'h01; rv[2] = 8'h00; rv[3] = 8'h00; rv[4] = 8'h00;
        do_run({$urandom, $urandom}, 1'b0, -1, 1'b0);

        // Random runs: a base pattern with sparse flips; odd runs spam start/challenge.
        for (int i = 0; i < 6; i++) begin
            base = 8'($urandom);
            for (int e = 0; e < N; e++) rv[e] = base ^ 8'($urandom & $urandom & $urandom);
            do_run({$urandom, $urandom}, i[0], -1, 1'b0);
            if (i[0]) begin
                repeat (20) @(negedge Clk);
                chk("spam_single_run_busy", 64'(busy), 64'(0));
                chk("spam_single_run_kv", 64'(key_valid), 64'(1));
            end
        end

        // start held through DONE, then the second run is aborted by reset.
        for (int e = 0; e < N; e++) rv[e] = 8'($urandom);
        do_run({$urandom, $urandom}, 1'b0, -1, 1'b1);
        repeat (10) @(negedge Clk);
        reset_check("abort_restart");

        // Reset at evaluation 3, then a fresh full run.
        for (int e = 0; e < N; e++) rv[e] = 8'hC3;
        do_run({$urandom, $urandom}, 1'b0, 2, 1'b0);
        for (int e = 0; e < N; e++) rv[e] = 8'h5A ^ 8'($urandom & $urandom & $urandom);
        do_run({$urandom, $urandom}, 1'b0, -1, 1'b0);

        // Single-evaluation instance.
        @(negedge Clk);
        challenge1 = 64'h0123456789ABCDEF;
        start1 = 1'b1;
        t0 = cyc;
        @(negedge Clk);
        start1 = 1'b0;
        challenge1 = {$urandom, $urandom};
        t = 0;
        while (!excite_l1 && t < 40) begin
            @(negedge Clk);
            t++;
            puf_resp1 = 8'($urandom);
        end
        chk("n1_first_excite", 64'(cyc - t0), 64'(S + 1));
        repeat (R) begin
            @(negedge Clk);
            puf_resp1 = 8'($urandom);
        end
        @(negedge Clk);
        puf_resp1 = 8'h3C;
        t = 0;
        do begin
            @(negedge Clk);
            t++;
            puf_resp1 = 8'($urandom);
        end while (!key_valid1 && t < 20);
        chk("n1_latency", 64'(cyc - t0), 64'(PER + 2));
        chk("n1_key", 64'(key1), 64'(8'h3C));
        chk("n1_unstable", 64'(unstable1), 64'(0));
        chk("n1_eval_idx", 64'(eval_idx1), 64'(1));
        chk("n1_chal_out", chal_out1, 64'h0123456789ABCDEF);
        repeat (6) @(negedge Clk);
        chk("n1_kv_hold", 64'(key_valid1), 64'(1));
        chk("n1_key_hold", 64'(key1), 64'(8'h3C));
        start1 = 1'b1;
        @(negedge Clk);
        start1 = 1'b0;
        chk("n1_restart_kv", 64'(key_valid1), 64'(0));
        chk("n1_restart_key", 64'(key1), 64'(8'h3C));
        chk("n1_restart_busy", 64'(busy1), 64'(1));

        repeat (2) @(negedge Clk);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));
        chk("excite_paths_equal", 64'(exc_bad), 64'(0));
        chk("chal_out_stable", 64'(chal_bad), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_chk);
        $fatal(1);
    end

endmodule

// File: doc/puf_key_gen.md
Name: puf_key_gen

Overview:
- Parametrised key-generation controller for an array of external arbiter-type PUF instances.
- Sequences a repeated settle/excite/sample cycle on a latched challenge.
- Majority-votes NUM_EVALS responses per PUF bit to produce a stable key, plus a mask of unstable (non-unanimous) bits.
- Sits between the PUF array and downstream key consumers; replaces free-running single-shot excitation with a start/valid handshake.

Parameters:
- NUM_PUF, 8, number of PUF instances; equals key width.
- CHAL_W, 64, challenge width driven to every PUF.
- SETTLE_CYCLES, 100, cycles with excite low before each excitation (>=1).
- RESP_DELAY, 2, cycles from excite pulse to response sampling (>=1).
- NUM_EVALS, 7, evaluations per key; must be odd and >=1.

Ports:
- Clk  in  1  single clock, rising edge.
- Rst_n  in  1  asynchronous active-low reset.
- start  in  1  request a key generation; accepted only in IDLE.
- challenge  in  CHAL_W  challenge; latched on start acceptance.
- puf_resp  in  NUM_PUF  response bits from PUF instances.
- chal_out  out  CHAL_W  latched challenge to PUFs.
- excite_l  out  1  left-path excite pulse.
- excite_r  out  1  right-path excite pulse.
- busy  out  1  high from acceptance until key_valid.
- key_valid  out  1  key/unstable valid; level signal.
- key  out  NUM_PUF  majority-voted key.
- unstable  out  NUM_PUF  bit i = 1 if PUF i votes not unanimous.
- eval_idx  out  clog2(NUM_EVALS+1)  evaluations completed in current run.

Behaviour:
- Reset (async assert, sync release): state=IDLE; all outputs 0, including chal_out; vote counters 0.
- All outputs are registered; excite_l and excite_r are always equal.
- IDLE: start=1 -> latch challenge into chal_out, clear vote counters, eval_idx=0, busy=1, key_valid=0, go to SETTLE. start outside IDLE is ignored (no queueing).
- SETTLE: excite low for exactly SETTLE_CYCLES cycles, then EXCITE.
- EXCITE: excite_l/r = 1 for exactly one cycle, then WAIT.
- WAIT: RESP_DELAY cycles; puf_resp is not sampled. Then SAMPLE.
- SAMPLE (1 cycle): for each bit i, ones_cnt[i] += puf_resp[i]; eval_idx += 1. If eval_idx reaches NUM_EVALS, go to DONE; else go to SETTLE.
- Per-evaluation length: SETTLE_CYCLES + RESP_DELAY + 2 cycles.
- Counter width: ones_cnt[i] is clog2(NUM_EVALS+1) bits and never wraps.
- DONE (1 cycle):
  - key[i] = (2*ones_cnt[i] > NUM_EVALS).
  - unstable[i] = (ones_cnt[i] != 0) && (ones_cnt[i] != NUM_EVALS).
  - key_valid=1, busy=0, then IDLE.
- Hold rules:
  - key, unstable and key_valid hold until the next accepted start, which clears key_valid in the acceptance cycle.
  - key/unstable keep old values until the next DONE.
- chal_out is constant from acceptance to DONE; changes on the challenge input mid-run have no effect.
- Latency, start accepted at cycle 0: key_valid high at cycle NUM_EVALS*(SETTLE_CYCLES+RESP_DELAY+2)+2.
- NUM_EVALS=1: single evaluation; unstable is always 0.
- start high in the same cycle key_valid rises (state DONE): ignored; it is accepted next cycle if still high in IDLE.
- Reset mid-run: immediate abort to IDLE with all outputs 0; a partial key is never exposed.

Test Plan (NUM_PUF=8, CHAL_W=64, SETTLE_CYCLES=4, RESP_DELAY=2, NUM_EVALS=5 unless noted):
- Reset then idle 20 cycles, no start -> all outputs 0; excite never pulses.
- start 1 cycle, challenge=64'h05055F5F55252F2F, puf_resp constant 8'hA5 -> chal_out=64'h05055F5F55252F2F; exactly 5 excite pulses 8 cycles apart; key_valid at cycle 42; key=8'hA5; unstable=8'h00.
- puf_resp sampled per eval as 8'hFF,8'h00,8'hFF,8'h0F,8'hF0 -> ones per bit 3 -> key=8'hFF, unstable=8'hFF; then sequence 8'h01,8'h01,8'h00,8'h00,8'h00 -> key=8'h00, unstable=8'h01.
- start pulsed repeatedly and challenge changed during busy -> single run; chal_out unchanged; eval_idx ends at 5.
- Rst_n low mid-run at eval 3 -> outputs 0 immediately; after release plus new start, fresh 5-eval run and correct key.
- NUM_EVALS=1, puf_resp=8'h3C -> key=8'h3C, unstable=0, key_valid at cycle 10; key holds and key_valid stays high until next start clears it.
